// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: opcodes, state enum,
// mux-select encodings and the control word the decoder produces per state.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_MEM_ADDR  = 4'd3,
    ST_MEM_READ  = 4'd4,
    ST_MEM_WB    = 4'd5,
    ST_MEM_WRITE = 4'd6,
    ST_EXECUTE   = 4'd7,
    ST_R_WB      = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_JUMP      = 4'd10,
    ST_ADDI_EX   = 4'd11,
    ST_ADDI_WB   = 4'd12,
    ST_TRAP      = 4'd13
  } state_e;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // mem_wait marks states that hold until mem_ready; last marks an instruction's final state
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       mem_wait;
    logic       last;
  } ctrl_word_t;

  function automatic state_e decode_next(input logic [5:0] op);
    state_e nxt;
    case (op)
      OP_LW, OP_SW: nxt = ST_MEM_ADDR;
      OP_RTYPE:     nxt = ST_EXECUTE;
      OP_BEQ:       nxt = ST_BRANCH;
      OP_J:         nxt = ST_JUMP;
      OP_ADDI:      nxt = ST_ADDI_EX;
      default:      nxt = ST_TRAP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Pure combinational state -> control word table (Moore outputs, before
// the mem_ready gating applied by the FSM top).
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_e     state,
  output ctrl_word_t cw
);

  // Per-state control word; unlisted fields stay at zero
  always_comb begin
    cw = '0;
    case (state)
      ST_FETCH: begin
        cw.mem_read  = 1'b1;
        cw.ir_write  = 1'b1;
        cw.pc_write  = 1'b1;
        cw.alu_src_b = SRCB_FOUR;
        cw.alu_op    = ALUOP_ADD;
        cw.pc_source = PCSRC_ALU;
        cw.mem_wait  = 1'b1;
      end
      ST_DECODE: begin
        cw.alu_src_b = SRCB_IMM_SH;
        cw.alu_op    = ALUOP_ADD;
      end
      ST_MEM_ADDR, ST_ADDI_EX: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
        cw.alu_op    = ALUOP_ADD;
      end
      ST_MEM_READ: begin
        cw.mem_read = 1'b1;
        cw.i_or_d   = 1'b1;
        cw.mem_wait = 1'b1;
      end
      ST_MEM_WB: begin
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = 1'b1;
        cw.last       = 1'b1;
      end
      ST_MEM_WRITE: begin
        cw.mem_write = 1'b1;
        cw.i_or_d    = 1'b1;
        cw.mem_wait  = 1'b1;
        cw.last      = 1'b1;
      end
      ST_EXECUTE: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_B;
        cw.alu_op    = ALUOP_FUNCT;
      end
      ST_R_WB: begin
        cw.reg_write = 1'b1;
        cw.reg_dst   = 1'b1;
        cw.last      = 1'b1;
      end
      ST_BRANCH: begin
        cw.alu_src_a     = 1'b1;
        cw.alu_src_b     = SRCB_B;
        cw.alu_op        = ALUOP_SUB;
        cw.pc_write_cond = 1'b1;
        cw.pc_source     = PCSRC_ALUOUT;
        cw.last          = 1'b1;
      end
      ST_JUMP: begin
        cw.pc_write  = 1'b1;
        cw.pc_source = PCSRC_JUMP;
        cw.last      = 1'b1;
      end
      ST_ADDI_WB: begin
        cw.reg_write = 1'b1;
        cw.last      = 1'b1;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS-32 datapath: state register,
// memory stall watchdog, sticky trap and retired-instruction counter.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state_o,
  output logic             trap,
  output logic [CNT_W-1:0] retired
);

  localparam int STALL_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

  state_e             state_r;
  state_e             state_next_s;
  ctrl_word_t         cw_s;
  logic [STALL_W-1:0] stall_cnt_r;
  logic               stall_limit_s;
  logic               advance_s;
  logic               retire_s;
  logic               trap_r;
  logic [CNT_W-1:0]   retired_r;

  mips_ctrl_decode u_decode (
    .state (state_r),
    .cw    (cw_s)
  );

  // Memory states only complete on mem_ready; the watchdog fires on the last allowed stall cycle
  assign advance_s     = ~cw_s.mem_wait | mem_ready;
  assign stall_limit_s = (WAIT_LIMIT != 0) && (stall_cnt_r == STALL_W'(WAIT_LIMIT - 1));
  assign retire_s      = cw_s.last & advance_s;

  // Next-state selection
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:   state_next_s = ST_FETCH;
      ST_FETCH, ST_MEM_READ, ST_MEM_WRITE: begin
        if (mem_ready) begin
          if (state_r == ST_FETCH)         state_next_s = ST_DECODE;
          else if (state_r == ST_MEM_READ) state_next_s = ST_MEM_WB;
          else                             state_next_s = ST_FETCH;
        end else if (stall_limit_s) begin
          state_next_s = ST_TRAP;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_DECODE: state_next_s = decode_next(opcode);
      ST_MEM_ADDR: begin
        if (opcode == OP_LW)      state_next_s = ST_MEM_READ;
        else if (opcode == OP_SW) state_next_s = ST_MEM_WRITE;
        else                      state_next_s = ST_TRAP;
      end
      ST_EXECUTE: state_next_s = ST_R_WB;
      ST_ADDI_EX: state_next_s = ST_ADDI_WB;
      ST_MEM_WB, ST_R_WB, ST_BRANCH, ST_JUMP, ST_ADDI_WB: state_next_s = ST_FETCH;
      ST_TRAP:   state_next_s = ST_TRAP;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // State, stall counter, trap flag and retired counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      stall_cnt_r <= '0;
      trap_r      <= 1'b0;
      retired_r   <= '0;
    end else begin
      state_r <= state_next_s;
      if (cw_s.mem_wait && !mem_ready && (state_next_s == state_r)) begin
        stall_cnt_r <= stall_cnt_r + STALL_W'(1'b1);
      end else begin
        stall_cnt_r <= '0;
      end
      trap_r <= trap_r | (state_next_s == ST_TRAP);
      if (retire_s) begin
        retired_r <= retired_r + CNT_W'(1'b1);
      end else begin
        retired_r <= retired_r;
      end
    end
  end

  assign pc_write      = cw_s.pc_write & advance_s;
  assign pc_write_cond = cw_s.pc_write_cond;
  assign i_or_d        = cw_s.i_or_d;
  assign mem_read      = cw_s.mem_read;
  assign mem_write     = cw_s.mem_write;
  assign ir_write      = cw_s.ir_write & mem_ready;
  assign mem_to_reg    = cw_s.mem_to_reg;
  assign reg_dst       = cw_s.reg_dst;
  assign reg_write     = cw_s.reg_write;
  assign alu_src_a     = cw_s.alu_src_a;
  assign alu_src_b     = cw_s.alu_src_b;
  assign alu_op        = cw_s.alu_op;
  assign pc_source     = cw_s.pc_source;
  assign state_o       = state_r;
  assign trap          = trap_r;
  assign retired       = retired_r;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed, table-driven bench for mips_multicycle_ctrl plus hand-written
// sequences for reset, trap, stall watchdog and counter wrap.
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  localparam logic [5:0] OPC_R    = 6'b000000;
  localparam logic [5:0] OPC_LW   = 6'b100011;
  localparam logic [5:0] OPC_SW   = 6'b101011;
  localparam logic [5:0] OPC_BEQ  = 6'b000100;
  localparam logic [5:0] OPC_J    = 6'b000010;
  localparam logic [5:0] OPC_ADDI = 6'b001000;
  localparam logic [5:0] OPC_BAD  = 6'b111111;

  // {pc_write,pc_write_cond,i_or_d,mem_read,mem_write,ir_write,mem_to_reg,reg_dst,reg_write,alu_src_a}_srcb_aluop_pcsrc_trap
  localparam logic [16:0] C_IDLE       = 17'b0000000000_00_00_00_0;
  localparam logic [16:0] C_FETCH      = 17'b1001010000_01_00_00_0;
  localparam logic [16:0] C_FETCH_WAIT = 17'b0001000000_01_00_00_0;
  localparam logic [16:0] C_DECODE     = 17'b0000000000_11_00_00_0;
  localparam logic [16:0] C_MEM_ADDR   = 17'b0000000001_10_00_00_0;
  localparam logic [16:0] C_MEM_READ   = 17'b0011000000_00_00_00_0;
  localparam logic [16:0] C_MEM_WB     = 17'b0000001010_00_00_00_0;
  localparam logic [16:0] C_MEM_WRITE  = 17'b0010100000_00_00_00_0;
  localparam logic [16:0] C_EXECUTE    = 17'b0000000001_00_10_00_0;
  localparam logic [16:0] C_R_WB       = 17'b0000000110_00_00_00_0;
  localparam logic [16:0] C_BRANCH     = 17'b0100000001_00_01_01_0;
  localparam logic [16:0] C_JUMP       = 17'b1000000000_00_00_10_0;
  localparam logic [16:0] C_ADDI_EX    = 17'b0000000001_10_00_00_0;
  localparam logic [16:0] C_ADDI_WB    = 17'b0000000010_00_00_00_0;
  localparam logic [16:0] C_TRAP       = 17'b0000000000_00_00_00_1;

  logic        clk;
  logic        rst;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a, trap;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state_o;
  logic [31:0] retired;

  logic        w_pc_write, w_pc_write_cond, w_i_or_d, w_mem_read, w_mem_write, w_ir_write;
  logic        w_mem_to_reg, w_reg_dst, w_reg_write, w_alu_src_a, w_trap;
  logic [1:0]  w_alu_src_b, w_alu_op, w_pc_source;
  logic [3:0]  w_state_o;
  logic [3:0]  w_retired;

  logic [16:0] ctrl_obs;
  assign ctrl_obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, trap};

  int n_cmp = 0;
  int n_bad = 0;

  mips_multicycle_ctrl #(.WAIT_LIMIT(16), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state_o(state_o), .trap(trap), .retired(retired)
  );

  // Narrow-counter instance sharing the same stimulus, used for the wrap check
  mips_multicycle_ctrl #(.WAIT_LIMIT(16), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(w_pc_write), .pc_write_cond(w_pc_write_cond), .i_or_d(w_i_or_d),
    .mem_read(w_mem_read), .mem_write(w_mem_write), .ir_write(w_ir_write),
    .mem_to_reg(w_mem_to_reg), .reg_dst(w_reg_dst), .reg_write(w_reg_write),
    .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b), .alu_op(w_alu_op),
    .pc_source(w_pc_source), .state_o(w_state_o), .trap(w_trap), .retired(w_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [16:0] ctrl;
    logic [31:0] ret;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [5:0] op, input logic mr, input state_e st,
                     input logic [16:0] c, input logic [31:0] ret);
    vec_t v;
    v.op = op; v.mr = mr; v.st = st; v.ctrl = c; v.ret = ret;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input state_e st, input logic [16:0] c,
                         input logic [31:0] ret);
    chk({tag, " state"}, 32'(state_o), 32'(st));
    chk({tag, " ctrl"}, 32'(ctrl_obs), 32'(c));
    chk({tag, " retired"}, retired, ret);
  endtask

  // Inputs change just after the rising edge; outputs are checked at the falling edge
  task automatic step(input logic [5:0] op, input logic mr);
    @(posedge clk);
    #1;
    opcode    = op;
    mem_ready = mr;
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    chk_all({tag, " in reset"}, ST_IDLE, C_IDLE, 32'd0);
    chk({tag, " in reset retired4"}, 32'(w_retired), 32'd0);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    opcode    = OPC_R;
    mem_ready = 1'b0;

    // LW
    add(OPC_LW, 1'b1, ST_FETCH,     C_FETCH,     32'd0);
    add(OPC_LW, 1'b1, ST_DECODE,    C_DECODE,    32'd0);
    add(OPC_LW, 1'b1, ST_MEM_ADDR,  C_MEM_ADDR,  32'd0);
    add(OPC_LW, 1'b1, ST_MEM_READ,  C_MEM_READ,  32'd0);
    add(OPC_LW, 1'b1, ST_MEM_WB,    C_MEM_WB,    32'd0);
    // R, BEQ, J, SW: 14 cycles
    add(OPC_R,   1'b1, ST_FETCH,     C_FETCH,     32'd1);
    add(OPC_R,   1'b1, ST_DECODE,    C_DECODE,    32'd1);
    add(OPC_R,   1'b1, ST_EXECUTE,   C_EXECUTE,   32'd1);
    add(OPC_R,   1'b1, ST_R_WB,      C_R_WB,      32'd1);
    add(OPC_BEQ, 1'b1, ST_FETCH,     C_FETCH,     32'd2);
    add(OPC_BEQ, 1'b1, ST_DECODE,    C_DECODE,    32'd2);
    add(OPC_BEQ, 1'b1, ST_BRANCH,    C_BRANCH,    32'd2);
    add(OPC_J,   1'b1, ST_FETCH,     C_FETCH,     32'd3);
    add(OPC_J,   1'b1, ST_DECODE,    C_DECODE,    32'd3);
    add(OPC_J,   1'b1, ST_JUMP,      C_JUMP,      32'd3);
    add(OPC_SW,  1'b1, ST_FETCH,     C_FETCH,     32'd4);
    add(OPC_SW,  1'b1, ST_DECODE,    C_DECODE,    32'd4);
    add(OPC_SW,  1'b1, ST_MEM_ADDR,  C_MEM_ADDR,  32'd4);
    add(OPC_SW,  1'b1, ST_MEM_WRITE, C_MEM_WRITE, 32'd4);
    // ADDI with a 3-cycle fetch stall
    add(OPC_ADDI, 1'b0, ST_FETCH,    C_FETCH_WAIT, 32'd5);
    add(OPC_ADDI, 1'b0, ST_FETCH,    C_FETCH_WAIT, 32'd5);
    add(OPC_ADDI, 1'b0, ST_FETCH,    C_FETCH_WAIT, 32'd5);
    add(OPC_ADDI, 1'b1, ST_FETCH,    C_FETCH,      32'd5);
    add(OPC_ADDI, 1'b1, ST_DECODE,   C_DECODE,     32'd5);
    add(OPC_ADDI, 1'b1, ST_ADDI_EX,  C_ADDI_EX,    32'd5);
    add(OPC_ADDI, 1'b1, ST_ADDI_WB,  C_ADDI_WB,    32'd5);
    // SW with a 1-cycle write stall
    add(OPC_SW, 1'b1, ST_FETCH,     C_FETCH,     32'd6);
    add(OPC_SW, 1'b1, ST_DECODE,    C_DECODE,    32'd6);
    add(OPC_SW, 1'b1, ST_MEM_ADDR,  C_MEM_ADDR,  32'd6);
    add(OPC_SW, 1'b0, ST_MEM_WRITE, C_MEM_WRITE, 32'd6);
    add(OPC_SW, 1'b1, ST_MEM_WRITE, C_MEM_WRITE, 32'd6);
    // LW with a 1-cycle read stall
    add(OPC_LW, 1'b1, ST_FETCH,     C_FETCH,     32'd7);
    add(OPC_LW, 1'b1, ST_DECODE,    C_DECODE,    32'd7);
    add(OPC_LW, 1'b1, ST_MEM_ADDR,  C_MEM_ADDR,  32'd7);
    add(OPC_LW, 1'b0, ST_MEM_READ,  C_MEM_READ,  32'd7);
    add(OPC_LW, 1'b1, ST_MEM_READ,  C_MEM_READ,  32'd7);
    add(OPC_LW, 1'b1, ST_MEM_WB,    C_MEM_WB,    32'd7);
    add(OPC_R,  1'b0, ST_FETCH,     C_FETCH_WAIT, 32'd8);

    @(negedge clk);
    do_reset("power-on");

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].op, vq[i].mr);
      chk($sformatf("vec%0d state", i), 32'(state_o), 32'(vq[i].st));
      chk($sformatf("vec%0d ctrl", i), 32'(ctrl_obs), 32'(vq[i].ctrl));
      chk($sformatf("vec%0d retired", i), retired, vq[i].ret);
    end

    // Reset while stalled in FETCH, then restart
    do_reset("mid-fetch");
    step(OPC_R, 1'b1);
    chk_all("restart", ST_FETCH, C_FETCH, 32'd0);

    // Illegal opcode traps after DECODE and stays trapped
    do_reset("illegal");
    step(OPC_BAD, 1'b1);
    step(OPC_BAD, 1'b1);
    chk_all("illegal decode", ST_DECODE, C_DECODE, 32'd0);
    step(OPC_BAD, 1'b1);
    chk_all("illegal trap", ST_TRAP, C_TRAP, 32'd0);
    for (int k = 0; k < 4; k++) begin
      step(OPC_J, 1'b1);
      chk_all($sformatf("trap sticky%0d", k), ST_TRAP, C_TRAP, 32'd0);
    end

    // 16 stalled cycles in MEM_READ trip the watchdog
    do_reset("timeout");
    step(OPC_LW, 1'b1);
    step(OPC_LW, 1'b1);
    step(OPC_LW, 1'b1);
    chk_all("timeout addr", ST_MEM_ADDR, C_MEM_ADDR, 32'd0);
    for (int k = 0; k < 16; k++) begin
      step(OPC_LW, 1'b0);
      chk($sformatf("timeout stall%0d state", k), 32'(state_o), 32'(ST_MEM_READ));
    end
    step(OPC_LW, 1'b0);
    chk_all("timeout trap", ST_TRAP, C_TRAP, 32'd0);
    step(OPC_LW, 1'b1);
    chk_all("timeout sticky", ST_TRAP, C_TRAP, 32'd0);

    // mem_ready on the limit cycle wins over the watchdog
    do_reset("limit-ready");
    step(OPC_LW, 1'b1);
    step(OPC_LW, 1'b1);
    step(OPC_LW, 1'b1);
    for (int k = 0; k < 15; k++) begin
      step(OPC_LW, 1'b0);
    end
    step(OPC_LW, 1'b1);
    chk_all("limit-ready read", ST_MEM_READ, C_MEM_READ, 32'd0);
    step(OPC_LW, 1'b1);
    chk_all("limit-ready wb", ST_MEM_WB, C_MEM_WB, 32'd0);
    step(OPC_LW, 1'b1);
    chk_all("limit-ready fetch", ST_FETCH, C_FETCH, 32'd1);

    // 16 jumps wrap the 4-bit counter
    do_reset("wrap");
    for (int j = 0; j < 16; j++) begin
      step(OPC_J, 1'b1);
      step(OPC_J, 1'b1);
      step(OPC_J, 1'b1);
      if (j == 15) begin
        chk_all("wrap last jump", ST_JUMP, C_JUMP, 32'd15);
        chk("wrap pre retired4", 32'(w_retired), 32'd15);
      end
    end
    step(OPC_J, 1'b1);
    chk_all("wrap after", ST_FETCH, C_FETCH, 32'd16);
    chk("wrap retired4", 32'(w_retired), 32'd0);
    chk("wrap trap4", 32'(w_trap), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
